blit_addr_step: RTL and testbench

The blitter address stepper reads the step register outputs STEP_0..STEP_7, STEPM1 and YFRAC, and applies them to a 20-bit blitter address. The address is advanced by 1 on each inner (pixel) step. On each outer (line) step it is advanced by the programmed step value, or by a fractional row pitch when YFRAC is set. It sits between the step/mode latches and the blitter address bus, and holds the inner-loop counter that tells the sequencer when a line is done.

---
 rtl/blit_pkg.sv | 6 +
 rtl/blit_addr_step_if.sv | 30 +++
 rtl/blit_yfrac_acc.sv | 34 +++
 rtl/blit_addr_step.sv | 84 ++++++++
 tb/tb_blit_addr_step.sv | 122 ++++++++++++
 5 files changed

// File: rtl/blit_pkg.sv
// blit_pkg: shared widths and step-kind decode for the blitter address stepper
package blit_pkg;
  localparam int ADDR_W = 20;
  localparam int FRAC_W = 8;
  typedef enum logic [1:0] {STEP_NONE, STEP_INNER, STEP_OUTER} step_kind_e;
endpackage

// File: rtl/blit_addr_step_if.sv
// blit_addr_step_if: step/mode/load inputs and address outputs of the blitter address stepper
interface blit_addr_step_if
  import blit_pkg::*;
#(
  parameter int ICNT_W = 8
);
  logic STEP_0, STEP_1, STEP_2, STEP_3, STEP_4, STEP_5, STEP_6, STEP_7;
  logic STEPM1;
  logic YFRAC;
  logic [ADDR_W-1:0] A_IN;
  logic LDADR;
  logic [ICNT_W-1:0] ICNT_IN;
  logic LDICNT;
  logic INNER;
  logic OUTER;
  logic [ADDR_W-1:0] ADDR;
  logic [FRAC_W-1:0] FRAC;
  logic INNER_DONE;
  logic YCARRY;
  modport master (
    output STEP_0, STEP_1, STEP_2, STEP_3, STEP_4, STEP_5, STEP_6, STEP_7,
    output STEPM1, YFRAC, A_IN, LDADR, ICNT_IN, LDICNT, INNER, OUTER,
    input  ADDR, FRAC, INNER_DONE, YCARRY
  );
  modport slave (
    input  STEP_0, STEP_1, STEP_2, STEP_3, STEP_4, STEP_5, STEP_6, STEP_7,
    input  STEPM1, YFRAC, A_IN, LDADR, ICNT_IN, LDICNT, INNER, OUTER,
    output ADDR, FRAC, INNER_DONE, YCARRY
  );
endinterface

// File: rtl/blit_yfrac_acc.sv
// blit_yfrac_acc: fractional-Y accumulator with carry-out and registered YCARRY pulse
module blit_yfrac_acc
  import blit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [FRAC_W-1:0] step,
  output logic [FRAC_W-1:0] frac,
  output logic              carry,
  output logic              ycarry
);
  logic [FRAC_W-1:0] frac_q, frac_d, sum;
  logic ycarry_q, ycarry_d;
  // add step to the fraction; a load clears it and suppresses the carry pulse
  always_comb begin
    {carry, sum} = {1'b0, frac_q} + {1'b0, step};
    frac_d = clr ? '0 : en ? sum : frac_q;
    ycarry_d = en && !clr && carry;
  end
  // fraction and carry-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      frac_q <= '0;
      ycarry_q <= 1'b0;
    end else begin
      frac_q <= frac_d;
      ycarry_q <= ycarry_d;
    end
  end
  assign frac = frac_q;
  assign ycarry = ycarry_q;
endmodule

// File: rtl/blit_addr_step.sv
// blit_addr_step: blitter address stepper (inner +1, outer step/fractional pitch); BLIT_PAGE_WRAP_EN keeps steps inside the 64K page
module blit_addr_step
  import blit_pkg::*;
#(
  parameter int ROW_PITCH = 256,
  parameter int ICNT_W    = 8
)(
  input logic MasterClock,
  input logic RESET,
  blit_addr_step_if.slave bus
);
  logic [7:0] step;
  step_kind_e kind;
  logic [ADDR_W-1:0] addr_q, addr_d, delta, sum, stepped;
  logic [ICNT_W-1:0] icnt_q, icnt_d;
  logic [ICNT_W:0] rem_q, rem_d;
  logic done_q, done_d;
  logic acc_en, carry, ycarry;
  logic [FRAC_W-1:0] frac;

  assign step = {bus.STEP_7, bus.STEP_6, bus.STEP_5, bus.STEP_4,
                 bus.STEP_3, bus.STEP_2, bus.STEP_1, bus.STEP_0};

  function automatic logic [ICNT_W:0] full_cnt(input logic [ICNT_W-1:0] v);
    return (v == '0) ? {1'b1, {ICNT_W{1'b0}}} : {1'b0, v};
  endfunction

  // outer beats inner; an inner step with nothing left to count is dropped
  always_comb begin
    kind = bus.OUTER ? STEP_OUTER : (bus.INNER && rem_q != '0) ? STEP_INNER : STEP_NONE;
    acc_en = (kind == STEP_OUTER) && bus.YFRAC;
  end

  blit_yfrac_acc u_acc (
    .clk   (MasterClock),
    .rst   (RESET),
    .clr   (bus.LDADR),
    .en    (acc_en),
    .step  (step),
    .frac  (frac),
    .carry (carry),
    .ycarry(ycarry)
  );

  // next address, remaining count and done flag
  always_comb begin
    delta = (kind == STEP_OUTER)
          ? (bus.YFRAC ? (carry ? ADDR_W'(ROW_PITCH) : '0)
                       : {{(ADDR_W-8){step[7]}}, step} - ADDR_W'(bus.STEPM1))
          : (kind == STEP_INNER) ? ADDR_W'(1) : '0;
    sum = addr_q + delta;
`ifdef BLIT_PAGE_WRAP_EN
    stepped = {addr_q[ADDR_W-1:16], sum[15:0]};
`else
    stepped = sum;
`endif
    addr_d = bus.LDADR ? bus.A_IN : stepped;
    icnt_d = bus.LDICNT ? bus.ICNT_IN : icnt_q;
    rem_d = bus.LDICNT ? full_cnt(bus.ICNT_IN)
          : (kind == STEP_OUTER) ? full_cnt(icnt_q)
          : (kind == STEP_INNER) ? rem_q - (ICNT_W+1)'(1) : rem_q;
    done_d = (rem_d == '0);
  end

  // address and inner-count registers
  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      addr_q <= '0;
      icnt_q <= '0;
      rem_q <= '0;
      done_q <= 1'b1;
    end else begin
      addr_q <= addr_d;
      icnt_q <= icnt_d;
      rem_q <= rem_d;
      done_q <= done_d;
    end
  end

  assign bus.ADDR = addr_q;
  assign bus.FRAC = frac;
  assign bus.INNER_DONE = done_q;
  assign bus.YCARRY = ycarry;
endmodule

// File: tb/tb_blit_addr_step.sv
// tb_blit_addr_step: directed scoreboard bench for the blitter address stepper
module tb_blit_addr_step;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int    due;
    string name;
    int    addr;
    int    frac;
    int    done;
    int    yc;
  } exp_t;
  exp_t q[$];

  blit_addr_step_if #(.ICNT_W(8)) bus();
  blit_addr_step #(.ROW_PITCH(256), .ICNT_W(8)) dut (
    .MasterClock(clk),
    .RESET      (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input int act, input int exp_v);
    if (exp_v >= 0) begin
      total_cnt++;
      if (act == exp_v) pass_cnt++;
      else $display("FAIL %s %s: got 0x%0h expected 0x%0h", nm, fld, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      automatic exp_t e = q.pop_front();
      if (e.due < cyc) begin
        total_cnt++;
        $display("FAIL %s: expectation missed at cycle %0d (due %0d)", e.name, cyc, e.due);
      end else begin
        chk(e.name, "ADDR", int'(bus.ADDR), e.addr);
        chk(e.name, "FRAC", int'(bus.FRAC), e.frac);
        chk(e.name, "INNER_DONE", int'(bus.INNER_DONE), e.done);
        chk(e.name, "YCARRY", int'(bus.YCARRY), e.yc);
      end
    end
  end

  task automatic go(input string nm, input logic r, input logic ld, input logic [19:0] a,
                    input logic li, input logic [7:0] ic, input logic inn, input logic outr,
                    input logic [7:0] st, input logic m1, input logic yf,
                    input int ea, input int ef, input int ed, input int ey);
    @(posedge clk);
    #1;
    rst = r;
    bus.LDADR = ld;
    bus.A_IN = a;
    bus.LDICNT = li;
    bus.ICNT_IN = ic;
    bus.INNER = inn;
    bus.OUTER = outr;
    {bus.STEP_7, bus.STEP_6, bus.STEP_5, bus.STEP_4,
     bus.STEP_3, bus.STEP_2, bus.STEP_1, bus.STEP_0} = st;
    bus.STEPM1 = m1;
    bus.YFRAC = yf;
    q.push_back('{cyc + 1, nm, ea, ef, ed, ey});
  endtask

  initial begin
    bus.LDADR = 0; bus.A_IN = 0; bus.LDICNT = 0; bus.ICNT_IN = 0;
    bus.INNER = 0; bus.OUTER = 0; bus.STEPM1 = 0; bus.YFRAC = 0;
    {bus.STEP_7, bus.STEP_6, bus.STEP_5, bus.STEP_4,
     bus.STEP_3, bus.STEP_2, bus.STEP_1, bus.STEP_0} = 8'h00;
    go("reset",     1, 0, 20'h0,     0, 8'd0, 0, 0, 8'h00, 0, 0, 'h0,     0,    1, 0);
    go("load",      0, 1, 20'h12345, 1, 8'd3, 0, 0, 8'h00, 0, 0, 'h12345, 0,    0, 0);
    go("inner1",    0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h12346, 0,    0, 0);
    go("inner2",    0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h12347, 0,    0, 0);
    go("inner3",    0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h12348, 0,    1, 0);
    go("overrun",   0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h12348, 0,    1, 0);
    go("ld100",     0, 1, 20'h00100, 0, 8'd0, 0, 0, 8'h00, 0, 0, 'h00100, 0,    1, 0);
    go("outer_neg", 0, 0, 20'h0,     0, 8'd0, 0, 1, 8'hFE, 1, 0, 'h000FD, 0,    0, 0);
    go("ld1000",    0, 1, 20'h01000, 0, 8'd0, 0, 0, 8'h00, 0, 0, 'h01000, 0,    0, 0);
    go("yfrac1",    0, 0, 20'h0,     0, 8'd0, 0, 1, 8'h80, 0, 1, 'h01000, 'h80, 0, 0);
    go("yfrac2",    0, 0, 20'h0,     0, 8'd0, 0, 1, 8'h80, 0, 1, 'h01100, 'h00, 0, 1);
    go("yfrac3",    0, 0, 20'h0,     0, 8'd0, 0, 1, 8'h80, 1, 1, 'h01100, 'h80, 0, 0);
    go("idle",      0, 0, 20'h0,     0, 8'd0, 0, 0, 8'h00, 0, 0, 'h01100, 'h80, 0, 0);
    go("ldFFFFF",   0, 1, 20'hFFFFF, 0, 8'd0, 0, 0, 8'h00, 0, 0, 'hFFFFF, 0,    0, 0);
`ifdef BLIT_PAGE_WRAP_EN
    go("wrap20",    0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'hF0000, 0,    0, 0);
    go("ld3FFFF",   0, 1, 20'h3FFFF, 0, 8'd0, 0, 0, 8'h00, 0, 0, 'h3FFFF, 0,    0, 0);
    go("wrap16",    0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h30000, 0,    0, 0);
`else
    go("wrap20",    0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h00000, 0,    0, 0);
    go("ld3FFFF",   0, 1, 20'h3FFFF, 0, 8'd0, 0, 0, 8'h00, 0, 0, 'h3FFFF, 0,    0, 0);
    go("wrap16",    0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h40000, 0,    0, 0);
`endif
    go("ld_outer",  0, 1, 20'h00500, 0, 8'd0, 0, 1, 8'h10, 0, 0, 'h00500, 0,    0, 0);
    go("out_inn",   0, 0, 20'h0,     0, 8'd0, 1, 1, 8'h10, 0, 0, 'h00510, 0,    0, 0);
    go("reload1",   0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h00511, 0,    0, 0);
    go("reload2",   0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h00512, 0,    0, 0);
    go("reload3",   0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h00513, 0,    1, 0);
    go("icnt0",     0, 0, 20'h0,     1, 8'd0, 0, 0, 8'h00, 0, 0, 'h00513, 0,    0, 0);
    for (int k = 1; k <= 256; k++)
      go("icnt0_run", 0, 0, 20'h0,   0, 8'd0, 1, 0, 8'h00, 0, 0, 'h00513 + k, 0, (k == 256) ? 1 : 0, 0);
    go("icnt0_end", 0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h00613, 0,    1, 0);
    go("mid_load",  0, 1, 20'h00777, 1, 8'd5, 0, 0, 8'h00, 0, 0, 'h00777, 0,    0, 0);
    go("mid_yfrac", 0, 0, 20'h0,     0, 8'd0, 0, 1, 8'hC0, 0, 1, 'h00777, 'hC0, 0, 0);
    go("mid_inner", 0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h00778, 'hC0, 0, 0);
    go("mid_reset", 1, 1, 20'h00999, 1, 8'd2, 1, 1, 8'h40, 0, 1, 'h00000, 0,    1, 0);
    go("post_rst",  0, 0, 20'h0,     0, 8'd0, 1, 0, 8'h00, 0, 0, 'h00000, 0,    1, 0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expectations never checked, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
